// File: rtl/fp_add_master.sv
// Avalon-MM master for the FP-add accelerator: writes operand A, operand B and
// the GO word, then reads back the result, with a bounded wait for readdatavalid.
module fp_add_master #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1,
    parameter int GO_ADDR  = 3,
    parameter int RES_ADDR = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
);

    // The counter only has to reach TIMEOUT-1: the TIMEOUT-th wait cycle ends the read.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_GO,
        S_RD_REQ,
        S_RD_WAIT,
        S_FIN
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] opb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              timeout_err_q;
    logic [ADDR_W-1:0] m_address_q;
    logic              m_write_q;
    logic [DATA_W-1:0] m_writedata_q;
    logic              m_read_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            opb_q         <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            m_address_q   <= '0;
            m_write_q     <= 1'b0;
            m_writedata_q <= '0;
            m_read_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Operand A goes straight onto the bus; only B needs holding.
                        opb_q         <= operand_b;
                        busy_q        <= 1'b1;
                        m_write_q     <= 1'b1;
                        m_address_q   <= ADDR_W'(OPA_ADDR);
                        m_writedata_q <= operand_a;
                        state_q       <= S_WR_A;
                    end
                end
                S_WR_A: begin
                    if (!m_waitrequest) begin
                        m_address_q   <= ADDR_W'(OPB_ADDR);
                        m_writedata_q <= opb_q;
                        state_q       <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (!m_waitrequest) begin
                        m_address_q   <= ADDR_W'(GO_ADDR);
                        m_writedata_q <= '0;
                        state_q       <= S_WR_GO;
                    end
                end
                S_WR_GO: begin
                    if (!m_waitrequest) begin
                        m_write_q   <= 1'b0;
                        m_read_q    <= 1'b1;
                        m_address_q <= ADDR_W'(RES_ADDR);
                        state_q     <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!m_waitrequest) begin
                        m_read_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Data arriving on the last permitted cycle still counts as success.
                    if (m_readdatavalid) begin
                        result_q      <= m_readdata;
                        timeout_err_q <= 1'b0;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_FIN;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q      <= '0;
                        timeout_err_q <= 1'b1;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    m_write_q <= 1'b0;
                    m_read_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign timeout_err = timeout_err_q;
    assign m_address   = m_address_q;
    assign m_write     = m_write_q;
    assign m_writedata = m_writedata_q;
    assign m_read      = m_read_q;

endmodule

// File: tb/tb_fp_add_master.sv
// Scoreboard bench for fp_add_master: an Avalon slave model with configurable
// stalls and read latency, a reference FP adder in real arithmetic, and a done monitor.
module tb_fp_add_master;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, timeout_err;
    logic [31:0] result;
    logic [2:0]  m_address;
    logic        m_write, m_read;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic        m_waitrequest = 1'b0;

    fp_add_master #(
        .ADDR_W(3), .DATA_W(32), .OPA_ADDR(0), .OPB_ADDR(1),
        .GO_ADDR(3), .RES_ADDR(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result), .timeout_err(timeout_err),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_read(m_read), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        terr;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_txn = 0;
    int          wait_cfg = 0;
    int          rd_delay = 1;
    int          stray_cnt = 0;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic [31:0] last_res = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference adder: single -> double, add in real arithmetic, back to single.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return 32'd0;
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(110, 145));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Slave model: drives waitrequest/readdatavalid at the falling edge, checks the
    // command sequence and command stability under stall.
    initial begin : slave
        int          phase;
        int          wait_left;
        int          rd_cnt;
        int          stray_seen;
        bit          in_cmd;
        logic [36:0] held;
        logic [36:0] cur;
        logic [31:0] reg_a, reg_b, res_reg;
        phase = 0; wait_left = 0; rd_cnt = 0; stray_seen = 0; in_cmd = 0;
        held = '0; reg_a = '0; reg_b = '0; res_reg = '0;
        forever begin
            @(negedge clk);
            m_readdatavalid = 1'b0;
            if (!reset_n) begin
                m_waitrequest = 1'b0;
                in_cmd = 0; phase = 0; rd_cnt = 0; stray_seen = stray_cnt;
                continue;
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    m_readdatavalid = 1'b1;
                    m_readdata = res_reg;
                end
            end else if (stray_seen != stray_cnt) begin
                stray_seen = stray_cnt;
                m_readdatavalid = 1'b1;
                m_readdata = $urandom;
            end
            cur = {m_write, m_read, m_address, m_writedata};
            if (m_write || m_read) begin
                if (in_cmd) begin
                    chk("cmd_stable", 96'(cur), 96'(held));
                end else begin
                    wait_left = wait_cfg;
                    held = cur;
                    chk("no_wr_rd_overlap", 96'(m_write & m_read), 96'(0));
                end
                if (wait_left > 0) begin
                    m_waitrequest = 1'b1;
                    wait_left--;
                    in_cmd = 1;
                end else begin
                    m_waitrequest = 1'b0;
                    in_cmd = 0;
                    case (phase)
                        0: begin
                            chk("wr_a_cmd", 96'(cur), 96'({1'b1, 1'b0, 3'd0, exp_a}));
                            reg_a = m_writedata;
                        end
                        1: begin
                            chk("wr_b_cmd", 96'(cur), 96'({1'b1, 1'b0, 3'd1, exp_b}));
                            reg_b = m_writedata;
                        end
                        2: begin
                            chk("wr_go_cmd", 96'(cur), 96'({1'b1, 1'b0, 3'd3, 32'd0}));
                            res_reg = fp_add(reg_a, reg_b);
                        end
                        default: begin
                            chk("rd_cmd", 96'(cur[36:32]), 96'({1'b0, 1'b1, 3'd4}));
                            rd_cnt = rd_delay;
                        end
                    endcase
                    phase = (phase + 1) % 4;
                end
            end else begin
                m_waitrequest = 1'b0;
            end
        end
    end

    // Completion monitor: pops the oldest expected response on every done pulse.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result 0x%0h, expected no response (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_txn++;
                chk("result", 96'(result), 96'(e.res));
                chk("timeout_err", 96'(timeout_err), 96'(e.terr));
                chk("latency", 96'(cyc - e.cyc), 96'(e.lat));
                chk("busy_at_done", 96'(busy), 96'(0));
                last_res = e.res;
                $display("txn %0d: result=0x%08h timeout_err=%0b latency=%0d (expected 0x%08h %0b %0d)",
                         n_txn, result, timeout_err, cyc - e.cyc, e.res, e.terr, e.lat);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called just after a falling edge with the DUT idle; off shifts the expected
    // acceptance cycle when start is raised one cycle early (in FIN).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int w,
                         input int d, input int hold, input int off);
        exp_t e;
        wait_cfg = w;
        rd_delay = d;
        exp_a = a;
        exp_b = b;
        e.terr = !(d >= 1 && d <= TIMEOUT);
        e.res  = e.terr ? 32'd0 : fp_add(a, b);
        e.cyc  = cyc + off;
        e.lat  = (e.terr ? 5 + TIMEOUT : 5 + d) + 4 * w;
        sb_q.push_back(e);
        start = 1'b1;
        operand_a = a;
        operand_b = b;
        repeat (hold) step();
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: %0d responses outstanding after %0d cycles, expected 0",
                     sb_q.size(), n);
            sb_q.delete();
        end
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outputs", 96'({busy, done, timeout_err, m_write, m_read, m_address, result, m_writedata}),
            96'(0));
        step();
        step();
        reset_n = 1'b1;
        step();

        // Zero-wait slave: 1.0 + 2.0
        issue(32'h3F80_0000, 32'h4000_0000, 0, 1, 1, 0);
        wait_done();
        // Three stall cycles on every command
        issue(32'h3F80_0000, 32'h4000_0000, 3, 1, 1, 0);
        wait_done();
        // Slave never returns data: timeout
        issue(32'h3F80_0000, 32'h4000_0000, 0, 0, 1, 0);
        wait_done();
        // Data on the very last wait cycle wins over the timeout
        issue(32'h4120_0000, 32'h3F00_0000, 1, TIMEOUT, 1, 0);
        wait_done();

        // start re-pulsed while busy with a different operand
        issue(32'h4080_0000, 32'hC000_0000, 1, 2, 1, 0);
        step();
        chk("busy_while_running", 96'(busy), 96'(1));
        start = 1'b1;
        operand_a = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        wait_done();

        // Stray readdatavalid while idle must not disturb the held result
        stray_cnt++;
        repeat (3) step();
        chk("stray_rdv_result", 96'(result), 96'(last_res));

        // Asynchronous reset while WR_B is stalled
        issue(32'h3F80_0000, 32'h4000_0000, 3, 1, 1, 0);
        n = 0;
        while (!(m_write && m_address == 3'd1 && m_waitrequest) && n < 50) begin
            step();
            n++;
        end
        chk("reached_wr_b_stall", 96'({m_write, m_address, m_waitrequest}), 96'({1'b1, 3'd1, 1'b1}));
        reset_n = 1'b0;
        #1;
        chk("reset_mid_op", 96'({m_write, m_read, busy, done}), 96'(0));
        sb_q.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
        issue(32'h3F80_0000, 32'h4000_0000, 0, 1, 1, 0);
        wait_done();

        // Back-to-back: start raised in FIN (ignored) and held into the next IDLE cycle
        issue(32'h3F80_0000, 32'h4000_0000, 0, 1, 1, 0);
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        chk("b2b_first_done", 96'(done), 96'(1));
        issue(32'h3F80_0000, 32'hC040_0000, 0, 1, 2, 1);
        wait_done();

        // Randomized operands, stall counts and read latencies
        for (int i = 0; i < 24; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : (r >= 8) ? r : (r % 3) + 1;
            issue(rnd_fp(), rnd_fp(), $urandom_range(0, 2), d, 1, 0);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
